// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART-to-Wishbone command bridge.
// Provides command/response byte codes, the FSM state encoding and the
// transmit guard length used by the serializer.
package uart_wb_pkg;

    localparam logic [7:0] CMD_READ  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
    localparam logic [7:0] CMD_GO    = 8'h67;  // 'g'

    localparam logic [7:0] RSP_OK  = 8'h2E;    // '.'
    localparam logic [7:0] RSP_ERR = 8'h21;    // '!'

    // tx_busy is not trusted in the tx_wr cycle and the two cycles after it,
    // because the UART takes that long to raise busy.
    localparam logic [1:0] TX_GUARD = 2'd3;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAddr = 3'd1,
        StData = 3'd2,
        StWb   = 3'd3,
        StTx   = 3'd4
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_GO);
    endfunction

endpackage

// File: rtl/uart_wb_txser.sv
// MSB-first byte serializer towards the UART transmitter.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   start_i           load word_i/count_i (count is 1 or 4 bytes)
//   word_i            bytes to send, first byte in [31:24]
//   count_i           number of bytes to send
//   tx_busy_i         UART transmitter busy
//   tx_data_o/tx_wr_o byte and one-cycle write strobe to the UART
//   done_o            all bytes sent and transmitter idle (one cycle)
module uart_wb_txser
    import uart_wb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] word_i,
    input  logic [2:0]  count_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_wr_o,
    output logic        done_o
);

    logic [31:0] sh_q, sh_d;
    logic [2:0]  left_q, left_d;
    logic [1:0]  guard_q, guard_d;
    logic        active_q, active_d;
    logic [7:0]  data_q, data_d;
    logic        wr_q, wr_d;

    assign done_o    = active_q && (left_q == 3'd0) && (guard_q == 2'd0) && !tx_busy_i;
    assign tx_data_o = data_q;
    assign tx_wr_o   = wr_q;

    always_comb begin
        sh_d     = sh_q;
        left_d   = left_q;
        guard_d  = guard_q;
        active_d = active_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        if (guard_q != 2'd0) begin
            guard_d = guard_q - 2'd1;
        end
        if (start_i) begin
            sh_d     = word_i;
            left_d   = count_i;
            active_d = 1'b1;
        end else if (active_q && (guard_q == 2'd0) && !tx_busy_i) begin
            if (left_q != 3'd0) begin
                wr_d    = 1'b1;
                data_d  = sh_q[31:24];
                sh_d    = {sh_q[23:0], 8'h00};
                left_d  = left_q - 3'd1;
                guard_d = TX_GUARD;
            end else begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q     <= '0;
            left_q   <= '0;
            guard_q  <= '0;
            active_q <= 1'b0;
            data_q   <= '0;
            wr_q     <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            left_q   <= left_d;
            guard_q  <= guard_d;
            active_q <= active_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// Serial debug/loader command responder: decodes 'r', 'w' and 'g' commands
// from UART bytes, runs single 32-bit Wishbone cycles and answers on UART tx.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   rx_data/rx_avail/rx_ack         UART receive byte handshake
//   tx_data/tx_wr/tx_busy           UART transmit byte handshake
//   wb_*                            Wishbone master (single cycles, sel=F)
//   go_stb/go_adr                   jump request from a 'g' command
//   busy                            FSM not idle
module uart_wb_bridge
    import uart_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned WB_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        go_stb,
    output logic [31:0] go_adr,
    output logic        busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned WW = $clog2(WB_TIMEOUT + 1);
    localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT);
    localparam logic [WW-1:0] WbLast = WW'(WB_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [WW-1:0] wbt_q, wbt_d;
    logic          rx_ack_q, rx_ack_d;
    logic          go_stb_q, go_stb_d;
    logic [31:0]   go_adr_q, go_adr_d;

    logic          take;
    logic          ser_start;
    logic [31:0]   ser_word;
    logic [2:0]    ser_count;
    logic          ser_done;

    assign rx_ack   = rx_ack_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = {4{cyc_q}};
    assign go_stb   = go_stb_q;
    assign go_adr   = go_adr_q;
    assign busy     = (state_q != StIdle);

    // A byte is only taken when rx_ack is low, so intake can never happen
    // on consecutive cycles.
    assign take = rx_avail && !rx_ack_q &&
                  ((state_q == StIdle) || (state_q == StAddr) || (state_q == StData));

    // Response selection; only sampled by the serializer on ser_start.
    always_comb begin
        if (!wb_ack_i) begin
            ser_word  = {RSP_ERR, 24'h0};
            ser_count = 3'd1;
        end else if (we_q) begin
            ser_word  = {RSP_OK, 24'h0};
            ser_count = 3'd1;
        end else begin
            ser_word  = wb_dat_i;
            ser_count = 3'd4;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        wbt_d     = wbt_q;
        rx_ack_d  = 1'b0;
        go_stb_d  = 1'b0;
        go_adr_d  = go_adr_q;
        ser_start = 1'b0;

        if (take) begin
            rx_ack_d = 1'b1;
            tmo_d    = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (take && is_cmd(rx_data)) begin
                    cmd_d   = rx_data;
                    cnt_d   = 2'd0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (take) begin
                    adr_d = {adr_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        case (cmd_q)
                            CMD_READ: begin
                                we_d    = 1'b0;
                                cyc_d   = 1'b1;
                                wbt_d   = '0;
                                state_d = StWb;
                            end
                            CMD_WRITE: state_d = StData;
                            default: begin
                                go_adr_d = {adr_q[23:0], rx_data};
                                go_stb_d = 1'b1;
                                state_d  = StIdle;
                            end
                        endcase
                    end
                end else if (tmo_q >= TmoMax) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (take) begin
                    dat_d = {dat_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        cyc_d   = 1'b1;
                        wbt_d   = '0;
                        state_d = StWb;
                    end
                end else if (tmo_q >= TmoMax) begin
                    state_d = StIdle;
                end
            end
            StWb: begin
                if (wb_ack_i || (wbt_q == WbLast)) begin
                    cyc_d     = 1'b0;
                    ser_start = 1'b1;
                    state_d   = StTx;
                end else begin
                    wbt_d = wbt_q + WW'(1);
                end
            end
            StTx: begin
                if (ser_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            wbt_q    <= '0;
            rx_ack_q <= 1'b0;
            go_stb_q <= 1'b0;
            go_adr_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            wbt_q    <= wbt_d;
            rx_ack_q <= rx_ack_d;
            go_stb_q <= go_stb_d;
            go_adr_q <= go_adr_d;
        end
    end

    uart_wb_txser u_txser (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .start_i   (ser_start),
        .word_i    (ser_word),
        .count_i   (ser_count),
        .tx_busy_i (tx_busy),
        .tx_data_o (tx_data),
        .tx_wr_o   (tx_wr),
        .done_o    (ser_done)
    );

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: UART and Wishbone slave models plus a
// command-level reference model (shadow memory, expected response bytes).
module tb_uart_wb_bridge;

    localparam int unsigned TMO = 300;
    localparam int unsigned WBT = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_avail = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        go_stb;
    logic [31:0] go_adr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_wb_bridge #(.TIMEOUT(TMO), .WB_TIMEOUT(WBT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .go_stb   (go_stb),
        .go_adr   (go_adr),
        .busy     (busy)
    );

    // ---------------- environment (UART + Wishbone slave) ----------------
    logic [7:0]  txq[$];
    logic [31:0] slv_mem [logic [31:0]];
    int          wb_wr_cnt = 0, wb_rd_cnt = 0, go_cnt = 0, ack_cnt = 0;
    int          cyc_len = 0, viol = 0, pend = 0, hold = 0, lat = 0;
    logic [31:0] last_adr = 0, last_dat = 0, cyc_adr = 0;
    logic        prev_cyc = 1'b0, prev_ack = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (prev_ack && rx_ack) viol++;
        if (rx_ack) ack_cnt++;
        prev_ack = rx_ack;
        // UART tx: busy rises 2 cycles after tx_wr and holds a random time
        if (tx_wr && (pend != 0 || tx_busy)) viol++;
        if (hold > 0) begin
            hold--;
            if (hold == 0) tx_busy = 1'b0;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                tx_busy = 1'b1;
                hold = $urandom_range(3, 9);
            end
        end
        if (tx_wr) begin
            txq.push_back(tx_data);
            pend = 2;
        end
        // Wishbone slave; addresses 0xDEADxxxx never ack
        if (wb_ack_i) begin
            wb_ack_i = 1'b0;
        end else if (wb_cyc_o) begin
            if (!prev_cyc) begin
                cyc_adr = wb_adr_o;
                lat = $urandom_range(0, 3);
                cyc_len = 0;
            end
            cyc_len++;
            if (wb_adr_o !== cyc_adr || wb_sel_o !== 4'hF || !wb_stb_o) viol++;
            wb_dat_i = $urandom;
            if (wb_adr_o[31:16] != 16'hDEAD) begin
                if (lat == 0) begin
                    wb_ack_i = 1'b1;
                    if (wb_we_o) begin
                        slv_mem[wb_adr_o] = wb_dat_o;
                        wb_wr_cnt++;
                        last_adr = wb_adr_o;
                        last_dat = wb_dat_o;
                    end else begin
                        wb_dat_i = slv_mem.exists(wb_adr_o) ? slv_mem[wb_adr_o]
                                                            : (wb_adr_o ^ 32'hA5A5_5A5A);
                        wb_rd_cnt++;
                    end
                end else begin
                    lat--;
                end
            end
        end
        prev_cyc = wb_cyc_o;
        if (go_stb) go_cnt++;
    end

    // ---------------- reference model ----------------
    logic [31:0] model_mem [logic [31:0]];
    logic [7:0]  exp_q[$];
    int          exp_wr = 0, exp_go = 0;
    logic [31:0] exp_go_adr = 0, exp_adr = 0, exp_dat = 0;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    task automatic model_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        exp_q.delete();
        if (c == 8'h72) begin
            if (a[31:16] == 16'hDEAD) exp_q.push_back(8'h21);
            else begin
                v = model_rd(a);
                for (int i = 3; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
            end
        end else if (c == 8'h77) begin
            if (a[31:16] == 16'hDEAD) exp_q.push_back(8'h21);
            else begin
                model_mem[a] = d;
                exp_wr++;
                exp_adr = a;
                exp_dat = d;
                exp_q.push_back(8'h2E);
            end
        end else if (c == 8'h67) begin
            exp_go++;
            exp_go_adr = a;
        end
    endtask

    // {length, up to 4 bytes} for compact response comparison
    function automatic logic [39:0] pack_q(input logic [7:0] q[$]);
        logic [39:0] r;
        r = {8'(q.size()), 32'h0};
        for (int i = 0; i < q.size() && i < 4; i++) r[31-8*i -: 8] = q[i];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data = b;
        rx_avail = 1'b1;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk);
            #2;
            if (rx_ack) break;
        end
        if (!rx_ack) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_ack_timeout byte=%02h got no ack want ack", b);
        end
        rx_avail = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        send_byte(c);
        if (c == 8'h72 || c == 8'h77 || c == 8'h67)
            for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (c == 8'h77)
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 5000; k++) begin
            if (!busy && !tx_busy && pend == 0) break;
            @(posedge clk);
            #2;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout busy=%0b want 0", busy);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if ({rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
             wb_stb_o, go_stb, go_adr, busy} !== '0)
            begin n_err++; $display("FAIL reset_outputs got nonzero adr=%h dat=%h busy=%b want 0",
                                    wb_adr_o, wb_dat_o, busy); end
        #3 reset_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_write_read();
        txq.delete();
        model_cmd(8'h77, 32'h0000_1000, 32'hDEAD_BEEF);
        send_cmd(8'h77, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_idle();
        n_cmp++;
        if (wb_wr_cnt != exp_wr) begin n_err++;
            $display("FAIL wr_count got %0d want %0d", wb_wr_cnt, exp_wr); end
        n_cmp++;
        if ({last_adr, last_dat} !== {32'h0000_1000, 32'hDEAD_BEEF}) begin n_err++;
            $display("FAIL wr_adr_dat got %h/%h want 00001000/deadbeef", last_adr, last_dat); end
        n_cmp++;
        if (pack_q(txq) !== pack_q(exp_q)) begin n_err++;
            $display("FAIL wr_resp got %h want %h", pack_q(txq), pack_q(exp_q)); end
        txq.delete();
        model_cmd(8'h72, 32'h0000_1000, 32'h0);
        send_cmd(8'h72, 32'h0000_1000, 32'h0);
        wait_idle();
        n_cmp++;
        if (pack_q(txq) !== 40'h04_DEAD_BEEF) begin n_err++;
            $display("FAIL rd_back got %h want 04deadbeef", pack_q(txq)); end
    endtask

    task automatic test_go();
        int wb0;
        wb0 = wb_wr_cnt + wb_rd_cnt;
        txq.delete();
        model_cmd(8'h67, 32'h0, 32'h0);
        send_cmd(8'h67, 32'h0, 32'h0);
        wait_idle();
        n_cmp++;
        if (go_cnt != exp_go) begin n_err++;
            $display("FAIL go_pulse_cycles got %0d want %0d", go_cnt, exp_go); end
        n_cmp++;
        if (go_adr !== exp_go_adr) begin n_err++;
            $display("FAIL go_adr got %h want %h", go_adr, exp_go_adr); end
        n_cmp++;
        if (wb_wr_cnt + wb_rd_cnt != wb0 || txq.size() != 0) begin n_err++;
            $display("FAIL go_side_effects got wb=%0d tx=%0d want wb=%0d tx=0",
                     wb_wr_cnt + wb_rd_cnt, txq.size(), wb0); end
    endtask

    task automatic test_junk();
        int a0;
        slv_mem[32'h4000_0004] = 32'h1234_5678;
        model_mem[32'h4000_0004] = 32'h1234_5678;
        a0 = ack_cnt;
        txq.delete();
        send_byte(8'h55);
        model_cmd(8'h72, 32'h4000_0004, 32'h0);
        send_cmd(8'h72, 32'h4000_0004, 32'h0);
        wait_idle();
        n_cmp++;
        if (ack_cnt - a0 != 6) begin n_err++;
            $display("FAIL junk_acks got %0d want 6", ack_cnt - a0); end
        n_cmp++;
        if (pack_q(txq) !== pack_q(exp_q)) begin n_err++;
            $display("FAIL junk_resp got %h want %h", pack_q(txq), pack_q(exp_q)); end
    endtask

    task automatic test_partial();
        int w0;
        w0 = wb_wr_cnt;
        txq.delete();
        send_byte(8'h77);
        send_byte(8'h00);
        send_byte(8'h01);
        repeat (TMO + 10) @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++;
            $display("FAIL partial_abandon got busy=%b want 0", busy); end
        model_cmd(8'h72, 32'h0, 32'h0);
        send_cmd(8'h72, 32'h0, 32'h0);
        wait_idle();
        n_cmp++;
        if (pack_q(txq) !== pack_q(exp_q) || wb_wr_cnt != w0) begin n_err++;
            $display("FAIL partial_then_read got %h wr=%0d want %h wr=%0d",
                     pack_q(txq), wb_wr_cnt, pack_q(exp_q), w0); end
    endtask

    task automatic test_no_ack();
        txq.delete();
        model_cmd(8'h72, 32'hDEAD_0000, 32'h0);
        send_cmd(8'h72, 32'hDEAD_0000, 32'h0);
        wait_idle();
        n_cmp++;
        if (cyc_len != int'(WBT)) begin n_err++;
            $display("FAIL noack_cyc_len got %0d want %0d", cyc_len, WBT); end
        n_cmp++;
        if (pack_q(txq) !== 40'h01_2100_0000) begin n_err++;
            $display("FAIL noack_rd_resp got %h want 0121000000", pack_q(txq)); end
        txq.delete();
        model_cmd(8'h77, 32'hDEAD_0010, 32'h1);
        send_cmd(8'h77, 32'hDEAD_0010, 32'h1);
        wait_idle();
        n_cmp++;
        if (pack_q(txq) !== pack_q(exp_q)) begin n_err++;
            $display("FAIL noack_wr_resp got %h want %h", pack_q(txq), pack_q(exp_q)); end
    endtask

    task automatic test_pending();
        txq.delete();
        model_cmd(8'h72, 32'h0000_0104, 32'h0);
        send_cmd(8'h72, 32'h0000_0104, 32'h0);
        send_byte(8'h67);  // arrives during WB/TX; must wait for the response
        n_cmp++;
        if (pack_q(txq) !== pack_q(exp_q)) begin n_err++;
            $display("FAIL pending_order got %h want %h", pack_q(txq), pack_q(exp_q)); end
        model_cmd(8'h67, 32'h0000_4000, 32'h0);
        for (int i = 3; i >= 0; i--) send_byte(8'(32'h0000_4000 >> (8 * i)));
        wait_idle();
        n_cmp++;
        if (go_adr !== exp_go_adr || go_cnt != exp_go) begin n_err++;
            $display("FAIL pending_go got %h/%0d want %h/%0d", go_adr, go_cnt, exp_go_adr, exp_go);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  c;
        logic [31:0] a, d;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: c = 8'h72;
                1: c = 8'h77;
                2: c = 8'h67;
                default: begin
                    c = 8'($urandom);
                    while (c == 8'h72 || c == 8'h77 || c == 8'h67) c = 8'($urandom);
                end
            endcase
            a = (c == 8'h67) ? $urandom : (32'h100 + 32'(4 * $urandom_range(0, 3)));
            d = $urandom;
            txq.delete();
            model_cmd(c, a, d);
            send_cmd(c, a, d);
            wait_idle();
            n_cmp++;
            if (pack_q(txq) !== pack_q(exp_q) || wb_wr_cnt != exp_wr || go_cnt != exp_go ||
                go_adr !== exp_go_adr) begin
                n_err++;
                $display("FAIL rand_cmd%0d c=%02h a=%h got %h wr=%0d go=%0d/%h want %h %0d %0d/%h",
                         n, c, a, pack_q(txq), wb_wr_cnt, go_cnt, go_adr, pack_q(exp_q),
                         exp_wr, exp_go, exp_go_adr);
            end
        end
        n_cmp++;
        if ({last_adr, last_dat} !== {exp_adr, exp_dat}) begin n_err++;
            $display("FAIL rand_last_write got %h/%h want %h/%h", last_adr, last_dat, exp_adr,
                     exp_dat); end
    endtask

    task automatic test_reset_mid();
        int k;
        txq.delete();
        send_cmd(8'h72, 32'hDEAD_0008, 32'h0);
        for (k = 0; k < 200; k++) begin
            if (wb_cyc_o) break;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({wb_cyc_o, wb_stb_o, tx_wr, rx_ack, busy} !== 5'b0) begin n_err++;
            $display("FAIL reset_mid got cyc/stb/wr/ack/busy=%b want 00000",
                     {wb_cyc_o, wb_stb_o, tx_wr, rx_ack, busy}); end
        exp_go_adr = 32'h0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        wait_idle();
        txq.delete();
        model_cmd(8'h72, 32'h0000_0108, 32'h0);
        send_cmd(8'h72, 32'h0000_0108, 32'h0);
        wait_idle();
        n_cmp++;
        if (pack_q(txq) !== pack_q(exp_q)) begin n_err++;
            $display("FAIL after_reset_rd got %h want %h", pack_q(txq), pack_q(exp_q)); end
    endtask

    task automatic test_protocol();
        n_cmp++;
        if (viol != 0) begin n_err++;
            $display("FAIL protocol_violations got %0d want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_go();
        test_junk();
        test_partial();
        test_no_ack();
        test_pending();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
